// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the 4-slot TDM receive path.
// Slot codes follow the transmitter's {s1,s0} select encoding.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT0 = 2'd0;
    localparam slot_t SLOT1 = 2'd1;
    localparam slot_t SLOT2 = 2'd2;
    localparam slot_t SLOT3 = slot_t'(NUM_SLOTS - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_demux4_if.sv
// Lane-side inputs and parallel channel outputs of the TDM demultiplexer.
interface tdm_demux4_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] ch0;
    logic [WIDTH-1:0] ch1;
    logic [WIDTH-1:0] ch2;
    logic [WIDTH-1:0] ch3;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  ch0, ch1, ch2, ch3, frame_valid, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output ch0, ch1, ch2, ch3, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux4_gap_timer.sv
// Mid-frame idle watchdog: counts enabled cycles and fires once MAX_GAP is reached.
// MAX_GAP = 0 disables the timeout entirely.
module tdm_gap_timer #(
    parameter int MAX_GAP = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;
    localparam logic [CW-1:0] LAST = (MAX_GAP > 0) ? CW'(MAX_GAP - 1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry acts on the edge that closes the MAX_GAP-th idle cycle.
    always_comb begin
        expire = (MAX_GAP > 0) && enable && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (clear || expire) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/tdm_demux4.sv
// TDM receive end: locks to the frame marker, collects four slots in shadow
// registers and publishes them together once per complete frame.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int MAX_GAP = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux4_if.slave   bus
);
    state_e state_q;
    state_e state_d;
    slot_t  slot_q;
    slot_t  slot_d;

    logic [NUM_SLOTS-2:0][WIDTH-1:0] shadow_q;
    logic [NUM_SLOTS-2:0][WIDTH-1:0] shadow_d;
    logic [NUM_SLOTS-1:0][WIDTH-1:0] ch_q;
    logic [NUM_SLOTS-1:0][WIDTH-1:0] ch_d;

    logic frame_valid_q;
    logic frame_valid_d;
    logic sync_err_q;
    logic sync_err_d;

    logic beat;
    logic gap_enable;
    logic gap_clear;
    logic gap_expire;

    assign beat = bus.din_valid;

    // Only a partially received frame can time out; any beat restarts the count.
    assign gap_enable = (state_q == LOCKED) && (slot_q != SLOT0) && !beat;
    assign gap_clear  = !gap_enable;

    tdm_gap_timer #(
        .MAX_GAP (MAX_GAP)
    ) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (gap_clear),
        .enable (gap_enable),
        .expire (gap_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: begin
                if (beat && bus.frame_sync) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (beat) begin
                    if ((slot_q == SLOT0) && !bus.frame_sync) begin
                        state_d = HUNT;
                    end
                end else if (gap_expire) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // An early marker restarts the frame at slot 0 rather than dropping lock.
    always_comb begin
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        ch_d          = ch_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        if (beat) begin
            if (bus.frame_sync) begin
                if ((state_q == LOCKED) && (slot_q != SLOT0)) begin
                    sync_err_d = 1'b1;
                end
                shadow_d[0] = bus.din;
                slot_d      = SLOT1;
            end else if (state_q == LOCKED) begin
                case (slot_q)
                    SLOT1: begin
                        shadow_d[1] = bus.din;
                        slot_d      = SLOT2;
                    end
                    SLOT2: begin
                        shadow_d[2] = bus.din;
                        slot_d      = SLOT3;
                    end
                    SLOT3: begin
                        ch_d          = {bus.din, shadow_q[2], shadow_q[1], shadow_q[0]};
                        frame_valid_d = 1'b1;
                        slot_d        = SLOT0;
                    end
                    default: begin
                        sync_err_d = 1'b1;
                    end
                endcase
            end
        end else if (gap_expire) begin
            sync_err_d = 1'b1;
            slot_d     = SLOT0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q        <= SLOT0;
            shadow_q      <= '0;
            ch_q          <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            ch_q          <= ch_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign bus.ch0         = ch_q[0];
    assign bus.ch1         = ch_q[1];
    assign bus.ch2         = ch_q[2];
    assign bus.ch3         = ch_q[3];
    assign bus.frame_valid = frame_valid_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed framing cases plus randomized
// traffic compared every cycle against a queue-based frame model.
module tb_tdm_demux4;
    import tdm_pkg::*;

    localparam int W       = 1;
    localparam int MAX_GAP = 16;

    logic clk;
    logic rst_n;

    tdm_demux4_if #(.WIDTH(W)) bus ();

    tdm_demux4 #(
        .WIDTH   (W),
        .MAX_GAP (MAX_GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fv_last = -100;
    int fv_prev = -100;

    // Frame-level reference: a queue of the slots received since the marker.
    logic         m_locked = 1'b0;
    logic [W-1:0] m_part[$];
    int           m_idle = 0;
    logic [W-1:0] exp_ch[0:NUM_SLOTS-1] = '{default: '0};
    logic         exp_fv  = 1'b0;
    logic         exp_err = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] d, input logic v, input logic s);
        bus.din        = d;
        bus.din_valid  = v;
        bus.frame_sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [0:3] f);
        for (int k = 0; k < NUM_SLOTS; k++) begin
            applyStimulus(W'(f[k]), 1'b1, k == 0);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked = 1'b0;
            m_part.delete();
            m_idle   = 0;
            for (int k = 0; k < NUM_SLOTS; k++) exp_ch[k] = '0;
            exp_fv   = 1'b0;
            exp_err  = 1'b0;
        end else begin
            exp_fv  = 1'b0;
            exp_err = 1'b0;
            if (bus.din_valid) begin
                m_idle = 0;
                if (!m_locked) begin
                    if (bus.frame_sync) begin
                        m_locked = 1'b1;
                        m_part.delete();
                        m_part.push_back(bus.din);
                    end
                end else if (bus.frame_sync) begin
                    if (m_part.size() != 0) exp_err = 1'b1;
                    m_part.delete();
                    m_part.push_back(bus.din);
                end else if (m_part.size() == 0) begin
                    exp_err  = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    m_part.push_back(bus.din);
                    if (m_part.size() == NUM_SLOTS) begin
                        for (int k = 0; k < NUM_SLOTS; k++) exp_ch[k] = m_part[k];
                        exp_fv = 1'b1;
                        m_part.delete();
                    end
                end
            end else if (m_locked && (m_part.size() != 0) && (MAX_GAP > 0)) begin
                m_idle++;
                if (m_idle == MAX_GAP) begin
                    exp_err  = 1'b1;
                    m_locked = 1'b0;
                    m_part.delete();
                    m_idle   = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("ch0", 32'(bus.ch0), 32'(exp_ch[0]));
        checkOutput("ch1", 32'(bus.ch1), 32'(exp_ch[1]));
        checkOutput("ch2", 32'(bus.ch2), 32'(exp_ch[2]));
        checkOutput("ch3", 32'(bus.ch3), 32'(exp_ch[3]));
        checkOutput("frame_valid", 32'(bus.frame_valid), 32'(exp_fv));
        checkOutput("locked", 32'(bus.locked), 32'(m_locked));
        checkOutput("sync_err", 32'(bus.sync_err), 32'(exp_err));
        if (bus.frame_valid) begin
            fv_prev = fv_last;
            fv_last = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind;
        rst_n          = 1'b0;
        bus.din        = '0;
        bus.din_valid  = 1'b1;
        bus.frame_sync = 1'b1;

        // Reset held with active-looking lane traffic.
        for (int i = 0; i < 4; i++) applyStimulus(W'(i), 1'b1, 1'b1);
        checkOutput("t1_rst_locked", 32'(bus.locked), 0);
        checkOutput("t1_rst_ch", 32'({bus.ch0, bus.ch1, bus.ch2, bus.ch3}), 0);
        rst_n = 1'b1;
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("t1_post_locked", 32'(bus.locked), 0);
        checkOutput("t1_post_fv", 32'(bus.frame_valid), 0);
        checkOutput("t1_post_err", 32'(bus.sync_err), 0);

        // Single frame 0101.
        sendFrame(4'b0101);
        checkOutput("t2_ch", 32'({bus.ch0, bus.ch1, bus.ch2, bus.ch3}), 32'b0101);
        checkOutput("t2_model_ch", 32'({exp_ch[0], exp_ch[1], exp_ch[2], exp_ch[3]}), 32'b0101);
        checkOutput("t2_fv", 32'(bus.frame_valid), 1);
        checkOutput("t2_locked", 32'(bus.locked), 1);

        // Back-to-back frames.
        sendFrame(4'b0101);
        sendFrame(4'b1001);
        checkOutput("t3_ch", 32'({bus.ch0, bus.ch1, bus.ch2, bus.ch3}), 32'b1001);
        checkOutput("t3_fv", 32'(bus.frame_valid), 1);
        @(negedge clk);
        checkOutput("t3_fv_spacing", 32'(fv_last - fv_prev), 4);
        @(posedge clk); #1;

        // Early marker at slot 2 restarts the frame.
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t4_err", 32'(bus.sync_err), 1);
        checkOutput("t4_keep_ch", 32'({bus.ch0, bus.ch1, bus.ch2, bus.ch3}), 32'b1001);
        checkOutput("t4_locked", 32'(bus.locked), 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t4_ch", 32'({bus.ch0, bus.ch1, bus.ch2, bus.ch3}), 32'b0101);
        checkOutput("t4_fv", 32'(bus.frame_valid), 1);

        // Missing marker at slot 0.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t5_err", 32'(bus.sync_err), 1);
        checkOutput("t5_locked", 32'(bus.locked), 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t5_hunt_err", 32'(bus.sync_err), 0);
        checkOutput("t5_hunt_locked", 32'(bus.locked), 0);
        sendFrame(4'b0110);
        checkOutput("t5_ch", 32'({bus.ch0, bus.ch1, bus.ch2, bus.ch3}), 32'b0110);

        // Gap timeout at exactly MAX_GAP idle cycles.
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (MAX_GAP - 1) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t6_pre_err", 32'(bus.sync_err), 0);
        checkOutput("t6_pre_locked", 32'(bus.locked), 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t6_err", 32'(bus.sync_err), 1);
        checkOutput("t6_locked", 32'(bus.locked), 0);

        // One idle cycle short of the timeout: frame completes.
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (MAX_GAP - 1) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t6b_ch", 32'({bus.ch0, bus.ch1, bus.ch2, bus.ch3}), 32'b1100);
        checkOutput("t6b_fv", 32'(bus.frame_valid), 1);
        checkOutput("t6b_locked", 32'(bus.locked), 1);

        // Randomized traffic: mostly clean frames with occasional faults.
        for (int it = 0; it < 400; it++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    repeat ($urandom_range(0, 2)) applyStimulus(W'($urandom), 1'b0, 1'($urandom));
                    applyStimulus(W'($urandom), 1'b1, k == 0);
                end
            end else if (kind == 6) begin
                repeat ($urandom_range(1, 4))
                    applyStimulus(W'($urandom), 1'b1, $urandom_range(0, 3) == 0);
            end else if (kind == 7) begin
                applyStimulus(W'($urandom), 1'b1, 1'b1);
                applyStimulus(W'($urandom), 1'b1, 1'b0);
                repeat ($urandom_range(MAX_GAP - 3, MAX_GAP + 2))
                    applyStimulus(W'($urandom), 1'b0, 1'b0);
            end else if (kind == 8) begin
                repeat ($urandom_range(1, 5)) applyStimulus(W'($urandom), 1'b0, 1'b0);
            end else begin
                applyStimulus(W'($urandom), 1'b1, 1'b1);
                rst_n = 1'b0;
                applyStimulus(W'($urandom), 1'b1, 1'b0);
                rst_n = 1'b1;
            end
        end

        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
